// File: rtl/fu_result_stage_if.sv
// ----------------------------------------------------------------------------
// fu_result_stage_if
// Bundles the upstream (FU -> stage) and downstream (stage -> writeback/PC)
// valid/ready channels of the FU result stage.
//   in_*  : FU result, CVZN flags, writeback tag, branch info, handshake
//   out_* : buffered head entry for writeback and branch resolution
// Modports:
//   slave  - the result stage itself (consumes in_*, produces out_*)
//   master - the surrounding environment (produces in_*, consumes out_*)
// ----------------------------------------------------------------------------
interface fu_result_stage_if #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [3:0]       in_status;
    logic             in_set_cc;
    logic             in_wr_en;
    logic [RA_W-1:0]  in_rd;
    logic             in_is_branch;
    logic [3:0]       in_cond;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_wr_en;
    logic [RA_W-1:0]  out_rd;
    logic             out_branch_taken;

    modport slave (
        input  in_valid, in_result, in_status, in_set_cc, in_wr_en, in_rd,
               in_is_branch, in_cond, out_ready,
        output in_ready, out_valid, out_data, out_wr_en, out_rd, out_branch_taken
    );

    modport master (
        output in_valid, in_result, in_status, in_set_cc, in_wr_en, in_rd,
               in_is_branch, in_cond, out_ready,
        input  in_ready, out_valid, out_data, out_wr_en, out_rd, out_branch_taken
    );
endinterface

// File: rtl/fu_result_stage.sv
// ----------------------------------------------------------------------------
// fu_result_stage
// Registered result stage behind the 16-bit functional unit. Holds up to two
// FU results in a FIFO, maintains the processor status register (PSR) and
// resolves conditional branches at accept time.
// Ports:
//   clk    - clock, all state changes on rising edge
//   rst_n  - synchronous reset, active low; clears buffer, storage and PSR
//   flush  - empties the buffer this cycle, PSR kept
//   bus    - in_*/out_* handshake channels (slave side)
//   psr    - current flags {V,C,Z,N} (bit 0 = N)
// ----------------------------------------------------------------------------
module fu_result_stage #(
    parameter int WIDTH = 16,
    parameter int RA_W  = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    fu_result_stage_if.slave    bus,
    output logic [3:0]          psr
);

    // Branch condition evaluation against a flag set {V,C,Z,N}.
    function automatic logic cond_eval(input logic [3:0] flags, input logic [3:0] cond);
        logic n, z, c, v;
        n = flags[0];
        z = flags[1];
        c = flags[2];
        v = flags[3];
        case (cond)
            4'h1:    cond_eval = 1'b1;
            4'h2:    cond_eval = z;
            4'h3:    cond_eval = ~z;
            4'h4:    cond_eval = c;
            4'h5:    cond_eval = ~c;
            4'h6:    cond_eval = n;
            4'h7:    cond_eval = ~n;
            4'h8:    cond_eval = v;
            4'h9:    cond_eval = ~v;
            4'hA:    cond_eval = n ^ v;
            4'hB:    cond_eval = ~(n ^ v);
            4'hC:    cond_eval = z | (n ^ v);
            4'hD:    cond_eval = ~(z | (n ^ v));
            default: cond_eval = 1'b0;
        endcase
    endfunction

    logic [WIDTH-1:0] r_data  [2];
    logic             r_wr_en [2];
    logic [RA_W-1:0]  r_rd    [2];
    logic             r_taken [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;
    logic [3:0]       r_psr;

    logic             w_accept;
    logic             w_pop;
    logic             w_taken;

    // in_ready never looks at out_ready, so a full buffer cannot push while popping.
    assign bus.in_ready = (r_count < 2'd2) & ~flush;
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_pop        = (r_count != 2'd0) & bus.out_ready & ~flush;

    // Resolved against the PSR before this entry's own set_cc takes effect;
    // every earlier set_cc entry has already updated r_psr when it was accepted.
    assign w_taken = bus.in_is_branch & cond_eval(r_psr, bus.in_cond);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_data[i]  <= '0;
                r_wr_en[i] <= 1'b0;
                r_rd[i]    <= '0;
                r_taken[i] <= 1'b0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
            r_psr   <= 4'b0000;
        end else if (flush) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_accept) begin
                r_data[r_wptr]  <= bus.in_result;
                r_wr_en[r_wptr] <= bus.in_wr_en;
                r_rd[r_wptr]    <= bus.in_rd;
                r_taken[r_wptr] <= w_taken;
                r_wptr          <= ~r_wptr;
                if (bus.in_set_cc) begin
                    r_psr <= bus.in_status;
                end
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.out_valid        = (r_count != 2'd0);
    assign bus.out_data         = r_data[r_rptr];
    assign bus.out_wr_en        = r_wr_en[r_rptr];
    assign bus.out_rd           = r_rd[r_rptr];
    assign bus.out_branch_taken = r_taken[r_rptr];
    assign psr                  = r_psr;

endmodule

// File: tb/tb_fu_result_stage.sv
module tb_fu_result_stage;

    typedef struct packed {
        logic [15:0] data;
        logic        wr_en;
        logic [4:0]  rd;
        logic        taken;
    } ent_t;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [3:0] psr;

    int errors;
    int checks;

    ent_t       q[$];
    logic [3:0] m_psr;

    fu_result_stage_if #(.WIDTH(16), .RA_W(5)) bus();

    fu_result_stage #(.WIDTH(16), .RA_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus),
        .psr   (psr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table with flags {V,C,Z,N}.
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v;
        n = f[0]; z = f[1]; cy = f[2]; v = f[3];
        case (c)
            4'h0: return 1'b0;
            4'h1: return 1'b1;
            4'h2: return z;
            4'h3: return !z;
            4'h4: return cy;
            4'h5: return !cy;
            4'h6: return n;
            4'h7: return !n;
            4'h8: return v;
            4'h9: return !v;
            4'hA: return n != v;
            4'hB: return n == v;
            4'hC: return z || (n != v);
            4'hD: return !(z || (n != v));
            default: return 1'b0;
        endcase
    endfunction

    // Advance one clock, updating the reference model from the inputs held this cycle.
    task automatic cycle();
        logic acc, pop;
        ent_t e;
        acc = bus.in_valid && (q.size() < 2) && !flush;
        pop = (q.size() != 0) && bus.out_ready && !flush;
        e.data  = bus.in_result;
        e.wr_en = bus.in_wr_en;
        e.rd    = bus.in_rd;
        e.taken = bus.in_is_branch && ref_cond(m_psr, bus.in_cond);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            m_psr = 4'b0000;
        end else if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                if (bus.in_set_cc) m_psr = bus.in_status;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] st,
                         input logic scc, input logic we, input logic [4:0] rd,
                         input logic br, input logic [3:0] cnd);
        bus.in_valid     = v;
        bus.in_result    = d;
        bus.in_status    = st;
        bus.in_set_cc    = scc;
        bus.in_wr_en     = we;
        bus.in_rd        = rd;
        bus.in_is_branch = br;
        bus.in_cond      = cnd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (psr !== 4'b0000) begin errors++; $display("FAIL reset_psr got %h want 0", psr); end
        checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", bus.out_data); end
        checks++; if (bus.out_rd !== 5'd0) begin errors++; $display("FAIL reset_out_rd got %0d want 0", bus.out_rd); end
        checks++; if (bus.out_wr_en !== 1'b0) begin errors++; $display("FAIL reset_out_wr_en got %b want 0", bus.out_wr_en); end
        checks++; if (bus.out_branch_taken !== 1'b0) begin errors++; $display("FAIL reset_taken got %b want 0", bus.out_branch_taken); end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h1234, 4'b0010, 1'b1, 1'b1, 5'd3, 1'b0, 4'h0);
        cycle();
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0, 4'h0);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h1234) begin errors++; $display("FAIL basic_data got %h want 1234", bus.out_data); end
        checks++; if (bus.out_rd !== 5'd3) begin errors++; $display("FAIL basic_rd got %0d want 3", bus.out_rd); end
        checks++; if (bus.out_wr_en !== 1'b1) begin errors++; $display("FAIL basic_wr_en got %b want 1", bus.out_wr_en); end
        checks++; if (psr !== 4'b0010) begin errors++; $display("FAIL basic_psr got %b want 0010", psr); end
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 4'h0, 1'b0, 1'b1, 5'd1, 1'b0, 4'h0);
        cycle();
        drive(1'b1, 16'hBBBB, 4'h0, 1'b0, 1'b1, 5'd2, 1'b0, 4'h0);
        cycle();
        drive(1'b1, 16'hCCCC, 4'h0, 1'b0, 1'b1, 5'd4, 1'b0, 4'h0);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", bus.in_ready); end
        cycle();
        checks++; if (bus.out_data !== 16'hAAAA) begin errors++; $display("FAIL bp_head_A got %h want aaaa", bus.out_data); end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_pop_ready got %b want 0", bus.in_ready); end
        cycle();
        checks++; if (bus.out_data !== 16'hBBBB) begin errors++; $display("FAIL bp_head_B got %h want bbbb", bus.out_data); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back got %b want 1", bus.in_ready); end
        cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_data !== 16'hCCCC || bus.out_rd !== 5'd4) begin errors++; $display("FAIL bp_head_C got %h/%0d want cccc/4", bus.out_data, bus.out_rd); end
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", bus.out_valid); end
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty_stays got %b want 0", bus.out_valid); end
    endtask

    task automatic test_branch_order();
        for (int rep = 0; rep < 2; rep++) begin
            bus.out_ready = 1'b0;
            drive(1'b1, 16'h0001, 4'b0010, 1'b1, 1'b0, 5'd0, 1'b0, 4'h0);
            cycle();
            drive(1'b1, 16'h0002, 4'b0000, 1'b0, 1'b0, 5'd0, 1'b1, (rep == 0) ? 4'h2 : 4'h3);
            cycle();
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            cycle();
            checks++;
            if (bus.out_data !== 16'h0002 || bus.out_branch_taken !== (rep == 0)) begin
                errors++; $display("FAIL branch_order_%0d got %h/%b want 0002/%b", rep, bus.out_data, bus.out_branch_taken, rep == 0);
            end
            cycle();
        end
        drive(1'b1, 16'h0003, 4'b0000, 1'b1, 1'b0, 5'd0, 1'b1, 4'h2);
        cycle();
        bus.in_valid = 1'b0;
        checks++; if (bus.out_branch_taken !== 1'b1) begin errors++; $display("FAIL branch_selfcc_taken got %b want 1", bus.out_branch_taken); end
        checks++; if (psr !== 4'b0000) begin errors++; $display("FAIL branch_selfcc_psr got %b want 0000", psr); end
        cycle();
    endtask

    task automatic test_conditions();
        logic [3:0]  flags [2];
        logic [15:0] masks [2];
        flags[0] = 4'b0001; masks[0] = 16'h166A;  // N=1 V=0 Z=0 C=0
        flags[1] = 4'b1001; masks[1] = 16'h296A;  // N=1 V=1 Z=0 C=0
        bus.out_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            drive(1'b1, 16'h0, flags[s], 1'b1, 1'b0, 5'd0, 1'b0, 4'h0);
            cycle();
            for (int c = 0; c < 16; c++) begin
                drive(1'b1, 16'(c), 4'h0, 1'b0, 1'b0, 5'd0, 1'b1, 4'(c));
                cycle();
                checks++;
                if (bus.out_branch_taken !== masks[s][c]) begin
                    errors++; $display("FAIL cond_%0d_%h got %b want %b", s, c, bus.out_branch_taken, masks[s][c]);
                end
            end
        end
        bus.in_valid = 1'b0;
        cycle();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h5555, 4'hF, 1'b1, 1'b1, 5'd7, 1'b0, 4'h0);
        cycle();
        cycle();
        drive(1'b1, 16'h6666, 4'b0101, 1'b1, 1'b1, 5'd8, 1'b0, 4'h0);
        flush = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
        cycle();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got %b want 0", bus.out_valid); end
        checks++; if (psr !== 4'hF) begin errors++; $display("FAIL flush_psr got %h want f", psr); end
        cycle();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h7777, 4'hF, 1'b1, 1'b1, 5'd9, 1'b0, 4'h0);
        cycle();
        cycle();
        bus.in_valid = 1'b0;
        checks++; if (psr !== 4'hF || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_setup got psr=%h v=%b want f/1", psr, bus.out_valid); end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", bus.out_valid); end
        checks++; if (psr !== 4'h0) begin errors++; $display("FAIL rstmid_psr got %h want 0", psr); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  5'($urandom), 1'($urandom), 4'($urandom));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 99) != 0);
            #1;
            checks++;
            if (bus.in_ready !== ((q.size() < 2) && !flush)) begin
                errors++; $display("FAIL rnd_in_ready cyc %0d got %b want %b", i, bus.in_ready, (q.size() < 2) && !flush);
            end
            cycle();
            checks++;
            if (bus.out_valid !== (q.size() != 0) || psr !== m_psr) begin
                errors++; $display("FAIL rnd_state cyc %0d got v=%b psr=%h want v=%b psr=%h", i, bus.out_valid, psr, q.size() != 0, m_psr);
            end
            if (q.size() != 0) begin
                checks++;
                if (bus.out_data !== q[0].data || bus.out_wr_en !== q[0].wr_en ||
                    bus.out_rd !== q[0].rd || bus.out_branch_taken !== q[0].taken) begin
                    errors++; $display("FAIL rnd_head cyc %0d got %h/%b/%0d/%b want %h/%b/%0d/%b", i,
                        bus.out_data, bus.out_wr_en, bus.out_rd, bus.out_branch_taken,
                        q[0].data, q[0].wr_en, q[0].rd, q[0].taken);
                end
            end
        end
        rst_n = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_psr  = 4'b0000;
        rst_n  = 1'b0;
        flush  = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 16'h0, 4'h0, 1'b0, 1'b0, 5'd0, 1'b0, 4'h0);
        test_reset();
        test_basic();
        test_backpressure();
        test_branch_order();
        test_conditions();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fu_result_stage.md
# fu_result_stage

Registered result stage directly downstream of the 16-bit functional unit. It accepts each FU result with its CVZN flags and writeback tag through a valid/ready handshake and holds them in a 2-entry buffer. It maintains the processor status register (PSR) and resolves branch conditions against it. Its output feeds register-file writeback and the branch/PC logic.

## Interface
Parameters:
- WIDTH, 16, data width of FU result and writeback data
- RA_W, 5, register-file address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous reset, active low
- flush  in  1  discard all buffered entries this cycle; PSR is kept
- in_valid  in  1  upstream entry present
- in_ready  out  1  stage can accept an entry
- in_result  in  WIDTH  FU result
- in_status  in  4  FU flags: [0]=N, [1]=Z, [2]=C, [3]=V
- in_set_cc  in  1  load in_status into PSR on accept
- in_wr_en  in  1  entry writes a register
- in_rd  in  RA_W  destination register
- in_is_branch  in  1  entry is a conditional branch
- in_cond  in  4  branch condition code
- out_valid  out  1  head entry present
- out_ready  in  1  downstream consumes head
- out_data  out  WIDTH  head result
- out_wr_en  out  1  head write enable; qualified by out_valid downstream
- out_rd  out  RA_W  head destination
- out_branch_taken  out  1  head is a branch and its condition held
- psr  out  4  current flags, same bit order as in_status

## Operation
- Accept is in_valid & in_ready & ~flush. Pop is out_valid & out_ready & ~flush.
- Buffer is a 2-entry FIFO with a count of 0..2.
  - in_ready = (count < 2) & ~flush. It depends on count and flush only, never on out_ready.
  - out_valid = (count != 0). Head fields come straight from the storage register.
- Accept and pop in the same cycle: count is unchanged; the entry order is preserved.
- flush: count becomes 0 at the next edge. Storage contents are don't-care. The PSR is unchanged.
- PSR update: on accept with in_set_cc=1, psr <= in_status. Otherwise psr holds.
- Branch resolution happens at accept time, against the PSR value before this entry's own update.
  - Stored taken bit = in_is_branch & cond_true. It is presented later as out_branch_taken.
  - Branches resolve in order against all earlier accepted set_cc entries, even if those are still buffered.
- Condition codes (N, Z, C, V are PSR bits):
  - 0 never; 1 always
  - 2 Z; 3 ~Z
  - 4 C; 5 ~C
  - 6 N; 7 ~N
  - 8 V; 9 ~V
  - A N^V; B ~(N^V)
  - C Z|(N^V); D ~(Z|(N^V))
  - E, F never
- in_result and flags are passed through unmodified; the stage does no arithmetic.

## Timing
- Reset (rst_n=0 at an edge):
  - count=0, psr=4'b0000
  - storage cleared, so out_data=0, out_rd=0, out_wr_en=0, out_branch_taken=0
  - out_valid=0, in_ready=1 from the first cycle after reset
- Reset mid-operation discards buffered entries and clears the PSR. Reset has priority over flush, accept and pop.
- Latency: an entry accepted at edge k gives out_valid=1 after edge k (1 cycle) if the buffer was empty. The PSR update is visible after edge k.
- Throughput: 1 entry/cycle sustained when out_ready=1.
- With out_ready=0, two entries are accepted, then in_ready=0. in_ready returns to 1 the cycle after the first pop.
- Full with out_ready=1: the pop occurs and in_ready stays 0 that cycle, so no push while full.
- Empty with out_ready=1: no pop; count stays 0.
- All outputs are registered or decoded from count. There is no combinational path from any input to out_* or psr. in_ready depends combinationally on flush.

## Test plan
- Reset, then accept in_result=16'h1234, in_rd=3, in_wr_en=1, in_set_cc=1, in_status=4'b0010 with out_ready=1 -> next cycle out_valid=1, out_data=16'h1234, out_rd=3, psr=4'b0010; one cycle later out_valid=0.
- Backpressure: out_ready=0, offer 3 entries (A, B, C) back-to-back -> A and B accepted, in_ready=0 on the third. Raise out_ready -> outputs A, B, C in order with no loss or duplication.
- Branch ordering: accept set_cc entry with status Z=1, then the same cycle's successor branch cond=2 while the first is still buffered -> out_branch_taken=1. Repeat with cond=3 -> 0. A branch carrying set_cc=1 with status Z=0 and cond=2 after a Z=1 PSR -> taken=1 and psr Z=0 afterwards.
- Signed conditions: psr N=1, V=0 -> cond A taken, B not, C taken, D not. psr N=1, V=1, Z=0 -> D taken. Cond 0, E, F are never taken; cond 1 is always taken.
- Flush with count=2 and a concurrent in_valid -> next cycle out_valid=0, nothing accepted, psr unchanged. Reset asserted with count=2 and psr=4'hF -> out_valid=0, psr=0, in_ready=1.
